// File: rtl/z80_bus_pkg.sv
// Shared types for the z80 external-bus bridge: FSM states, transaction kinds,
// the open-bus default byte and the strobe decoder used to start a transaction.
// Combinational helpers only; no latency, no backpressure.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_ACC,
        ST_IO_ACC,
        ST_INTA,
        ST_HOLD
    } bridge_state_t;

    typedef enum logic [1:0] {
        BK_MEM,
        BK_IO,
        BK_INTA
    } bus_kind_t;

    typedef struct packed {
        logic      hit;
        bus_kind_t kind;
    } start_dec_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

    // Priority decode of the core strobes: INTA beats a memory cycle, which
    // beats an I/O cycle. An INTA cycle drives M1_L and IORQ_L low together,
    // so I/O is only taken with M1_L high.
    function automatic start_dec_t decode_start(
        input logic mreq_l,
        input logic iorq_l,
        input logic rd_l,
        input logic wr_l,
        input logic m1_l
    );
        start_dec_t d;
        d.hit  = 1'b0;
        d.kind = BK_MEM;
        if (!m1_l && !iorq_l) begin
            d.hit  = 1'b1;
            d.kind = BK_INTA;
        end else if (!mreq_l && (!rd_l || !wr_l)) begin
            d.hit  = 1'b1;
            d.kind = BK_MEM;
        end else if (!iorq_l && m1_l && (!rd_l || !wr_l)) begin
            d.hit  = 1'b1;
            d.kind = BK_IO;
        end
        return d;
    endfunction

endpackage

// File: rtl/z80_wait_timer.sv
// Cycle counter bounding how long the bridge waits for a fabric ack.
// Latency: count updates one cycle after clear/load/inc; expired is combinational on the count.
// Backpressure: none; the counter saturates at TIMEOUT_CYC instead of wrapping.
//
// Ports: clk, rst_L (sync, active low), clear (highest priority), load/load_val,
//        inc, expired (count == TIMEOUT_CYC-1).
module z80_wait_timer #(
    parameter  int TIMEOUT_CYC = 255,
    localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic          clk,
    input  logic          rst_L,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          expired
);

    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_L || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST_CNT);

endmodule

// File: rtl/z80_bus_bridge.sv
// Bridges z80 bus strobes to req/ack memory and I/O fabrics and services INTA cycles.
// Latency: start cycle + >=1 req cycle; ack (or timeout) in a req cycle moves to HOLD next edge.
// Backpressure: WAIT_L stalls the core combinationally from the detection cycle until HOLD.
//
// Ports: clk, rst_L (sync, active low); core side addr_bus, cpu_wdata, cpu_rdata,
//        MREQ_L/IORQ_L/RD_L/WR_L/M1_L strobes, WAIT_L; memory fabric mem_req/we/addr/
//        wdata/rdata/ack; I/O fabric io_req/we/addr/wdata/rdata/ack; int_vec/int_ack
//        for interrupt acknowledge; bus_err pulses when an access times out.
module z80_bus_bridge
    import z80_bus_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 255,
    parameter logic [7:0] OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        M1_L,
    output logic        WAIT_L,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack,
    input  logic [7:0]  int_vec,
    output logic        int_ack,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    bridge_state_t state;
    start_dec_t    dec;
    logic          start;
    logic          in_acc;
    logic          expired;
    logic          cyc_we;

    assign dec    = decode_start(MREQ_L, IORQ_L, RD_L, WR_L, M1_L);
    // No new transaction is decoded while reset is asserted, so the core is
    // never stalled by a cycle that the coming reset edge would discard.
    assign start  = (state == ST_IDLE) && dec.hit && rst_L;
    assign in_acc = (state == ST_MEM_ACC) || (state == ST_IO_ACC);
    // RD_L and WR_L both low is treated as a read.
    assign cyc_we = !WR_L && RD_L;

    // Combinational so the core sees the stall in the same cycle the strobes appear.
    assign WAIT_L = ~(start || in_acc || (state == ST_INTA));

    z80_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .rst_L    (rst_L),
        .clear    (start),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .inc      (in_acc),
        .expired  (expired)
    );

    // Reqs are only ever high in their own *_ACC state, so checking the state
    // alone honours an ack only while the matching req is up.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state     <= ST_IDLE;
            cpu_rdata <= OPEN_BUS;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            int_ack   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (dec.kind)
                            BK_INTA: begin
                                // int_ack is high for the single INTA cycle;
                                // the vector is taken on the edge ending it.
                                int_ack <= 1'b1;
                                state   <= ST_INTA;
                            end
                            BK_MEM: begin
                                mem_req   <= 1'b1;
                                mem_we    <= cyc_we;
                                mem_addr  <= addr_bus;
                                mem_wdata <= cpu_wdata;
                                state     <= ST_MEM_ACC;
                            end
                            BK_IO: begin
                                io_req   <= 1'b1;
                                io_we    <= cyc_we;
                                io_addr  <= addr_bus[7:0];
                                io_wdata <= cpu_wdata;
                                state    <= ST_IO_ACC;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_MEM_ACC: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        cpu_rdata <= mem_we ? OPEN_BUS : mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= ST_HOLD;
                    end else if (expired) begin
                        cpu_rdata <= OPEN_BUS;
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_IO_ACC: begin
                    if (io_ack) begin
                        cpu_rdata <= io_we ? OPEN_BUS : io_rdata;
                        io_req    <= 1'b0;
                        state     <= ST_HOLD;
                    end else if (expired) begin
                        cpu_rdata <= OPEN_BUS;
                        io_req    <= 1'b0;
                        bus_err   <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_INTA: begin
                    cpu_rdata <= int_vec;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Waiting for the core to end its cycle; a strobe still
                    // held here must not start a second transaction.
                    if (MREQ_L && IORQ_L) begin
                        cpu_rdata <= OPEN_BUS;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
module tb_z80_bus_bridge;

    localparam int         K_MEM  = 0;
    localparam int         K_IO   = 1;
    localparam int         K_INTA = 2;
    localparam logic [7:0] OPEN   = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [15:0] addr_bus;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        MREQ_L, IORQ_L, RD_L, WR_L, M1_L;
    logic        WAIT_L;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        io_req, io_we;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        io_ack;
    logic [7:0]  int_vec;
    logic        int_ack, bus_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    z80_bus_bridge #(
        .TIMEOUT_CYC (4),
        .OPEN_BUS    (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .addr_bus  (addr_bus),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .MREQ_L    (MREQ_L),
        .IORQ_L    (IORQ_L),
        .RD_L      (RD_L),
        .WR_L      (WR_L),
        .M1_L      (M1_L),
        .WAIT_L    (WAIT_L),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobes_idle();
        MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
    endtask

    // One complete core cycle: drive strobes, play the fabric (ack in req cycle
    // ack_at, 0 = never), count stall cycles, check HOLD/no-retrigger/IDLE return.
    task automatic access(input string tag, input int kind, input logic [15:0] a,
                          input logic [7:0] wd, input logic wr, input logic both_low,
                          input int ack_at, input logic [7:0] rd, input int exp_low,
                          input logic exp_err);
        int   low, reqc, err_n, err_at, iack_n, iack_at;
        logic mem_seen, done;
        logic [7:0] exp_byte;

        if (kind == K_INTA)              exp_byte = rd;
        else if (wr || ack_at == 0)      exp_byte = OPEN;
        else                             exp_byte = rd;
        exp_q.push_back(exp_byte);

        addr_bus  = a;
        cpu_wdata = wd;
        int_vec   = rd;
        if (kind == K_INTA) begin
            // MREQ/RD also low so the memory decode competes and must lose.
            M1_L = 1'b0; IORQ_L = 1'b0; MREQ_L = 1'b0; RD_L = 1'b0; WR_L = 1'b1;
        end else begin
            M1_L   = 1'b1;
            MREQ_L = (kind == K_MEM) ? 1'b0 : 1'b1;
            IORQ_L = (kind == K_IO)  ? 1'b0 : 1'b1;
            RD_L   = (wr && !both_low) ? 1'b1 : 1'b0;
            WR_L   = (wr || both_low)  ? 1'b0 : 1'b1;
        end
        #1;
        check({tag, "_detect_wait"}, 32'(WAIT_L), 32'd0);
        low = (WAIT_L == 1'b0) ? 1 : 0;

        reqc = 0; err_n = 0; err_at = -1; iack_n = 0; iack_at = -1;
        mem_seen = 1'b0; done = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            tick();
            mem_ack = 1'b0;
            io_ack  = 1'b0;
            if (bus_err) begin err_n++; err_at = cyc; end
            if (int_ack) begin iack_n++; iack_at = cyc; end
            if (mem_req) mem_seen = 1'b1;
            if (WAIT_L) begin
                done = 1'b1;
            end else begin
                low++;
                if (mem_req || io_req) begin
                    reqc++;
                    if (kind == K_MEM) begin
                        check({tag, "_mem_addr"},  32'(mem_addr),  32'(a));
                        check({tag, "_mem_we"},    32'(mem_we),    32'(wr));
                        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(wd));
                    end else begin
                        check({tag, "_io_addr"},  32'(io_addr),  32'(a[7:0]));
                        check({tag, "_io_we"},    32'(io_we),    32'(wr));
                        check({tag, "_io_wdata"}, 32'(io_wdata), 32'(wd));
                    end
                    if (reqc == ack_at) begin
                        if (kind == K_MEM) begin mem_ack = 1'b1; mem_rdata = rd; end
                        else               begin io_ack  = 1'b1; io_rdata  = rd; end
                    end
                end
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_wait_low_cycles"}, 32'(low), 32'(exp_low));
        check({tag, "_bus_err_count"}, 32'(err_n), exp_err ? 32'd1 : 32'd0);
        if (exp_err) check({tag, "_bus_err_cycle"}, 32'(err_at), 32'(exp_low));
        if (kind == K_INTA) begin
            check({tag, "_int_ack_count"}, 32'(iack_n), 32'd1);
            check({tag, "_int_ack_cycle"}, 32'(iack_at), 32'd1);
        end
        if (kind != K_MEM) check({tag, "_no_mem_req"}, 32'(mem_seen), 32'd0);
        if (exp_q.size() > 0) check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(exp_q.pop_front()));
        check({tag, "_hold_req_low"}, 32'(mem_req | io_req), 32'd0);

        // Strobes still held: stay in HOLD, no second transaction.
        tick();
        check({tag, "_no_retrigger_wait"}, 32'(WAIT_L), 32'd1);
        check({tag, "_no_retrigger_req"}, 32'(mem_req | io_req), 32'd0);
        check({tag, "_hold_rdata"}, 32'(cpu_rdata), 32'(exp_byte));

        strobes_idle();
        tick();
        check({tag, "_idle_rdata"}, 32'(cpu_rdata), 32'(OPEN));
        check({tag, "_idle_wait"}, 32'(WAIT_L), 32'd1);
    endtask

    initial begin
        rst_L     = 1'b0;
        addr_bus  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        io_rdata  = '0;
        mem_ack   = 1'b0;
        io_ack    = 1'b0;
        int_vec   = '0;
        strobes_idle();
        tick();
        tick();
        check("rst_wait",      32'(WAIT_L),    32'd1);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_io_req",    32'(io_req),    32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_io_addr",   32'(io_addr),   32'd0);
        check("rst_int_ack",   32'(int_ack),   32'd0);
        check("rst_bus_err",   32'(bus_err),   32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'(OPEN));
        rst_L = 1'b1;
        tick();

        access("mem_rd",   K_MEM,  16'h1234, 8'h00, 1'b0, 1'b0, 3, 8'hA5, 4, 1'b0);
        access("mem_wr",   K_MEM,  16'h8000, 8'h3C, 1'b1, 1'b0, 1, 8'h11, 2, 1'b0);
        access("rdwr_low", K_MEM,  16'h0F0F, 8'hAA, 1'b0, 1'b1, 1, 8'h3D, 2, 1'b0);
        access("io_in",    K_IO,   16'h00FE, 8'h00, 1'b0, 1'b0, 2, 8'h7F, 3, 1'b0);
        access("io_out",   K_IO,   16'h1242, 8'h5E, 1'b1, 1'b0, 1, 8'h00, 2, 1'b0);
        access("inta_ff",  K_INTA, 16'h0000, 8'h00, 1'b0, 1'b0, 0, 8'hFF, 2, 1'b0);
        access("inta_c7",  K_INTA, 16'h0000, 8'h00, 1'b0, 1'b0, 0, 8'hC7, 2, 1'b0);
        access("timeout",  K_MEM,  16'h2222, 8'h00, 1'b0, 1'b0, 0, 8'h99, 5, 1'b1);

        // Late ack from the timed-out access must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 8'h42;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_req",   32'(mem_req),   32'd0);
        check("stray_ack_wait",  32'(WAIT_L),    32'd1);
        check("stray_ack_rdata", 32'(cpu_rdata), 32'(OPEN));
        check("stray_ack_err",   32'(bus_err),   32'd0);

        access("io_timeout", K_IO,  16'h0033, 8'h00, 1'b0, 1'b0, 0, 8'h55, 5, 1'b1);
        access("ack_on_4th", K_MEM, 16'h3333, 8'h00, 1'b0, 1'b0, 4, 8'h66, 5, 1'b0);

        // Reset in the middle of a memory access.
        addr_bus = 16'h4000;
        MREQ_L = 1'b0; RD_L = 1'b0;
        tick();
        check("rstmid_req_up", 32'(mem_req), 32'd1);
        tick();
        rst_L = 1'b0;
        tick();
        check("rstmid_req",   32'(mem_req),   32'd0);
        check("rstmid_wait",  32'(WAIT_L),    32'd1);
        check("rstmid_addr",  32'(mem_addr),  32'd0);
        check("rstmid_rdata", 32'(cpu_rdata), 32'(OPEN));
        rst_L     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        #1;
        check("rstmid_fresh_detect", 32'(WAIT_L), 32'd0);
        exp_q.push_back(8'h5A);
        tick();
        mem_ack = 1'b0;
        check("rstmid_fresh_req",  32'(mem_req),  32'd1);
        check("rstmid_fresh_wait", 32'(WAIT_L),   32'd0);
        check("rstmid_fresh_addr", 32'(mem_addr), 32'h4000);
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        check("rstmid_done_wait", 32'(WAIT_L), 32'd1);
        if (exp_q.size() > 0) check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
        strobes_idle();
        tick();
        check("rstmid_idle_rdata", 32'(cpu_rdata), 32'(OPEN));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
